shift_left: RTL and testbench



---
 rtl/shift_left.sv | 62 ++++++
 tb/tb_shift_left.sv | 136 +++++++++++++
 2 files changed

// File: rtl/shift_left.sv
// Registered jump-field shifter: out = {in, SHAMT'b0}, one-cycle latency.
// Define SHIFT_LEFT_JT_EN to add pc_hi and the registered 32-bit jump_target.
module shift_left #(
  parameter int IN_W  = 26,
  parameter int SHAMT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [IN_W-1:0]       in,
`ifdef SHIFT_LEFT_JT_EN
  input  logic [3:0]            pc_hi,
  output logic [31:0]           jump_target,
`endif
  output logic [IN_W+SHAMT-1:0] out,
  output logic                  out_valid,
  output logic                  out_zero
);

  localparam int OUT_W = IN_W + SHAMT;

  // Logical shift only: the index is an unsigned word count, never sign-extended.
  function automatic logic [OUT_W-1:0] word_to_byte(input logic [IN_W-1:0] idx);
    return {idx, {SHAMT{1'b0}}};
  endfunction

  logic [OUT_W-1:0] out_p0;
  logic             vld_p0;
  logic             zero_p0;

  // Stage 0: capture on en; reset takes priority and clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p0  <= '0;
      vld_p0  <= 1'b0;
      zero_p0 <= 1'b0;
    end else if (en) begin
      out_p0  <= word_to_byte(in);
      vld_p0  <= 1'b1;
      zero_p0 <= (in == '0);
    end
  end

`ifdef SHIFT_LEFT_JT_EN
  logic [31:0] jt_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      jt_p0 <= '0;
    end else if (en) begin
      jt_p0 <= {pc_hi, word_to_byte(in)};
    end
  end

  assign jump_target = jt_p0;
`endif

  assign out       = out_p0;
  assign out_valid = vld_p0;
  assign out_zero  = zero_p0;

endmodule

// File: tb/tb_shift_left.sv
// Directed self-checking bench for shift_left; exercises jump_target when
// built with SHIFT_LEFT_JT_EN.
module tb_shift_left;

  logic        clk;
  logic        rst;
  logic        en;
  logic [25:0] in;
  logic [27:0] out;
  logic        out_valid;
  logic        out_zero;
`ifdef SHIFT_LEFT_JT_EN
  logic [3:0]  pc_hi;
  logic [31:0] jump_target;
`endif

  int passed;
  int failed;
  int total;

  shift_left #(.IN_W(26), .SHAMT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .in          (in),
`ifdef SHIFT_LEFT_JT_EN
    .pc_hi       (pc_hi),
    .jump_target (jump_target),
`endif
    .out         (out),
    .out_valid   (out_valid),
    .out_zero    (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input logic r, input logic e, input logic [25:0] d);
    @(negedge clk);
    rst = r;
    en  = e;
    in  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    rst = 1'b1;
    en  = 1'b0;
    in  = '0;
`ifdef SHIFT_LEFT_JT_EN
    pc_hi = 4'h0;
`endif

    step(1'b1, 1'b1, 26'h3FFFFFF);
    step(1'b1, 1'b1, 26'h3FFFFFF);
    check("reset_out",   {4'h0, out}, 32'h0);
    check("reset_valid", {31'h0, out_valid}, 32'h0);
    check("reset_zero",  {31'h0, out_zero}, 32'h0);
`ifdef SHIFT_LEFT_JT_EN
    check("reset_jt",    jump_target, 32'h0);
`endif

    step(1'b0, 1'b0, 26'h0000001);
    check("idle_after_reset_valid", {31'h0, out_valid}, 32'h0);
    check("idle_after_reset_out",   {4'h0, out}, 32'h0);

    step(1'b0, 1'b1, 26'h0000001);
    check("basic_out",   {4'h0, out}, 32'h0000004);
    check("basic_valid", {31'h0, out_valid}, 32'h1);
    check("basic_zero",  {31'h0, out_zero}, 32'h0);

    step(1'b0, 1'b1, 26'h3FFFFFF);
    check("all_ones_out", {4'h0, out}, 32'h0FFFFFFC);
    step(1'b0, 1'b1, 26'h2000000);
    check("msb_out", {4'h0, out}, 32'h08000000);
    step(1'b0, 1'b1, 26'h0000000);
    check("zero_out",  {4'h0, out}, 32'h0);
    check("zero_flag", {31'h0, out_zero}, 32'h1);
    check("zero_valid", {31'h0, out_valid}, 32'h1);

    step(1'b0, 1'b1, 26'h0123456);
    check("capture_out",  {4'h0, out}, 32'h048D158);
    check("capture_zero", {31'h0, out_zero}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 26'h1555555);
      check("hold_out",   {4'h0, out}, 32'h048D158);
      check("hold_valid", {31'h0, out_valid}, 32'h1);
    end
    step(1'b0, 1'b0, 'x);
    check("hold_x_out",  {4'h0, out}, 32'h048D158);
    check("hold_x_zero", {31'h0, out_zero}, 32'h0);

    step(1'b0, 1'b1, 26'h0000001);
    check("b2b_1", {4'h0, out}, 32'h4);
    step(1'b0, 1'b1, 26'h0000002);
    check("b2b_2", {4'h0, out}, 32'h8);
    step(1'b0, 1'b1, 26'h0000003);
    check("b2b_3", {4'h0, out}, 32'hC);

    step(1'b1, 1'b1, 26'h0000005);
    check("rst_prio_out",   {4'h0, out}, 32'h0);
    check("rst_prio_valid", {31'h0, out_valid}, 32'h0);

    step(1'b0, 1'b1, 26'h0000007);
    check("resume_out",   {4'h0, out}, 32'h1C);
    check("resume_valid", {31'h0, out_valid}, 32'h1);

`ifdef SHIFT_LEFT_JT_EN
    pc_hi = 4'h8;
    step(1'b0, 1'b1, 26'h0100000);
    check("jt_target", jump_target, 32'h80400000);
    check("jt_out",    {4'h0, out}, 32'h0400000);
    pc_hi = 4'h3;
    step(1'b0, 1'b0, 26'h3FFFFFF);
    check("jt_hold", jump_target, 32'h80400000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
